// File: rtl/barker_transmitter_pkg.sv
// korelator_pkg: types and constants shared between the Barker transmit and receive paths.
package korelator_pkg;
  localparam int SAMPLE_W = 8;
  localparam logic [12:0] BARKER13 = 13'b1111100110101;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/barker_transmitter_if.sv
// barker_transmitter_if: control inputs and sample outputs of the Barker probe transmitter.
interface barker_transmitter_if;
  import korelator_pkg::*;
  logic ena;
  logic start;
  logic continuous;
  logic abort;
  logic signed [SAMPLE_W-1:0] tx;
  logic sync;
  logic busy;
  logic done;
  modport master (output ena, start, continuous, abort, input tx, sync, busy, done);
  modport slave (input ena, start, continuous, abort, output tx, sync, busy, done);
endinterface

// File: rtl/barker_transmitter_chip_timer.sv
// chip_timer: enable-gated prescaler, strobes chip_end on the last enabled cycle of each chip.
module chip_timer #(
  parameter int CHIP_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic chip_end
);
  logic [7:0] cnt_q, cnt_d;
  assign chip_end = en && cnt_q == 8'(CHIP_LEN - 1);
  always_comb cnt_d = (clr || chip_end) ? '0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/barker_transmitter.sv
// barker_transmitter: emits Barker probe bursts of +/-AMPL chips followed by a zero guard gap.
module barker_transmitter import korelator_pkg::*; #(
  parameter int CHIP_LEN = 4,
  parameter int AMPL = 100,
  parameter int CODE_LEN = 13,
  parameter logic [CODE_LEN-1:0] CODE = BARKER13,
  parameter int GAP = 64
) (
  input logic clk,
  input logic rst,
  barker_transmitter_if.slave bus
);
  localparam logic [8:0] NEG9 = 9'd0 - 9'(AMPL);
  localparam logic [SAMPLE_W-1:0] POS = SAMPLE_W'(AMPL);
  localparam logic [SAMPLE_W-1:0] NEG = NEG9[SAMPLE_W-1:0];
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [9:0] gap_q, gap_d;
  logic [SAMPLE_W-1:0] tx_q, tx_d;
  logic [CODE_LEN-1:0] code_sh;
  logic sync_q, sync_d, busy_q, busy_d, done_q, done_d;
  logic go, kill, chip_end, last_chip, gap_end, launch;
  chip_timer #(.CHIP_LEN(CHIP_LEN)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(go && state_q == SEND),
    .clr(launch || kill),
    .chip_end(chip_end)
  );
  always_comb begin
    go = bus.ena && !bus.abort;
    kill = bus.ena && bus.abort;
    last_chip = chip_end && idx_q == 4'(CODE_LEN - 1);
    gap_end = state_q == korelator_pkg::GAP && gap_q == 10'(GAP - 1);
    launch = go && ((state_q == IDLE && bus.start) || (gap_end && bus.continuous));
    state_d = state_q;
    idx_d = idx_q;
    gap_d = gap_q;
    if (kill || launch) begin
      state_d = kill ? IDLE : SEND;
      idx_d = '0;
      gap_d = '0;
    end else if (go) begin
      idx_d = last_chip ? '0 : chip_end ? idx_q + 4'd1 : idx_q;
      gap_d = (state_q == korelator_pkg::GAP && !gap_end) ? gap_q + 10'd1 : '0;
      state_d = last_chip ? korelator_pkg::GAP : gap_end ? IDLE : state_q;
    end
    // Outputs are computed from the next state so they line up with it after the edge.
    code_sh = CODE << idx_d;
    tx_d = !bus.ena ? tx_q : state_d == SEND ? (code_sh[CODE_LEN-1] ? POS : NEG) : '0;
    busy_d = bus.ena ? state_d != IDLE : busy_q;
    sync_d = launch;
    done_d = go && gap_end;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      gap_q <= '0;
      tx_q <= '0;
      sync_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      tx_q <= tx_d;
      sync_q <= sync_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.tx = tx_q;
  assign bus.sync = sync_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/barker_transmitter.md
Name: barker_transmitter

Overview:
- Transmit-side counterpart of the correlator receive path.
- On a start request, emits one Barker-13 probe burst as signed 8-bit samples (the format the receiver consumes on its sample input), followed by a zero-valued guard gap.
- Raises a one-cycle sync pulse on the first chip so the receiver's time-of-flight timer can be zeroed against it.
- Supports single-shot and continuous (repeating) operation.

Parameters:
- CHIP_LEN, 4: clock cycles each chip is held; legal range 1..255.
- AMPL, 100: chip magnitude. A '1' bit drives +AMPL; a '0' bit drives -AMPL. Legal range 1..127.
- CODE, 13'b1111100110101: chip sequence, sent MSB first.
- CODE_LEN, 13: number of chips.
- GAP, 64: guard cycles after the last chip, with tx = 0; legal range 1..1023.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable. When low, all state freezes.
- start  in  1  burst request; sampled only in IDLE.
- continuous  in  1  when high at end of GAP, the next burst starts immediately.
- abort  in  1  synchronous abort to IDLE.
- tx  out  8  signed transmit sample.
- sync  out  1  one-cycle pulse aligned with the first sample of each burst's chip 0.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse on the cycle after the last GAP cycle.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, all counters = 0, tx = 0, sync = 0, busy = 0, done = 0.
- Outputs: all outputs are registered.
- States: IDLE, SEND, GAP.
- IDLE:
  - tx = 0, busy = 0.
  - ena & start at edge N: state = SEND; chip index = 0; chip counter = 0.
  - First chip appears on tx at N+1, together with sync = 1 and busy = 1.
- SEND:
  - tx = CODE[CODE_LEN-1-idx] ? +AMPL : -AMPL (two's complement; 100 = 0x64, -100 = 0x9C).
  - The chip counter counts 0..CHIP_LEN-1. On wrap, idx increments.
  - After chip CODE_LEN-1 completes (CODE_LEN*CHIP_LEN cycles in SEND; 52 at defaults): state = GAP, tx = 0.
- GAP:
  - tx = 0, busy = 1, for exactly GAP cycles.
  - At the end of GAP, done pulses for one cycle.
  - If continuous = 1 at that edge: state = SEND; sync pulses together with done; busy stays 1.
  - Otherwise: state = IDLE; busy falls in the same cycle that done rises.
- start outside IDLE: ignored, with no queuing.
- abort: highest priority while ena = 1, in any state. The next cycle has state = IDLE, tx = 0, busy = 0, and no done pulse. abort together with start in IDLE gives IDLE.
- ena = 0:
  - Counters, state and tx hold.
  - sync and done are forced to 0; a pulse due in a frozen cycle is delivered on the first cycle after ena returns.
  - Burst timing, counted in enabled cycles, is unchanged.
- Arithmetic:
  - Chip counter is 8 bits, idx is 4 bits, gap counter is 10 bits.
  - Negation is computed at 9 bits and truncated. AMPL ≤ 127, so no overflow is possible.
- Total busy time per single-shot burst = CODE_LEN*CHIP_LEN + GAP enabled cycles (116 at defaults).

Decomposition:
- Shared package (korelator_pkg):
  - state enum {IDLE, SEND, GAP};
  - BARKER13 constant;
  - sample width constant SAMPLE_W = 8, shared with the receive path.
- Sub-module chip_timer:
  - enable-gated prescaler that produces a chip_end strobe every CHIP_LEN enabled cycles;
  - cleared on burst start and on abort.
- The FSM, chip index, gap counter and output mapping stay in barker_transmitter.

Test Plan:
- Reset and idle: hold rst = 0 with start toggling, then release and idle 10 cycles -> tx = 0, sync = 0, busy = 0, done = 0 throughout.
- Single burst at defaults: one start pulse at cycle N.
  - sync = 1 only at N+1.
  - tx = 0x64 for cycles N+1..N+20, then 0x9C for N+21..N+28, and so on following 1111100110101.
  - tx = 0 for N+53..N+116.
  - done = 1 at N+117, when busy = 0.
- Start while busy: start pulses at N+10 and N+60 -> no effect; still exactly one sync and one done.
- ena freeze: drop ena for 7 cycles during chip 3 -> tx holds 0x64; done shifts 7 cycles later (N+124); total chip count unchanged.
- Abort mid-SEND: abort at N+30 -> tx = 0 and busy = 0 at N+31; no done; a new start at N+35 gives a fresh sync at N+36 with chip 0.
- Continuous mode: continuous = 1 throughout -> sync pulses at N+1, N+117 and N+233, each coincident with done from N+117 onward; busy never drops.
